// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo
// Slave-side receive endpoint for the 8-bit four-phase req/ack byte link.
// Each byte presented by the master is acknowledged and stored in a small
// FIFO. Stored bytes are handed to the consumer over valid/ready. While the
// FIFO is full, ack is withheld so the master stalls and no data is lost.
//
// Parameters:
//   DATA_W  link / FIFO data width (default 8)
//   DEPTH   FIFO entries, power of two, >= 2 (default 4)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_in       master request; data_in valid while high
//   data_in      byte from master
//   ack_out      registered four-phase acknowledge
//   out_valid    FIFO non-empty
//   out_data     head-of-FIFO byte (meaningful only when out_valid=1)
//   out_ready    consumer accepts head byte
//   level        FIFO occupancy 0..DEPTH
//   byte_count   accepted bytes since reset, wraps 255->0
//   checksum_out XOR of all accepted bytes since reset
//                (present only when HSRX_CHECKSUM_EN is defined)
//
// Optional feature macro: HSRX_CHECKSUM_EN
module hs_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 byte_count
`ifdef HSRX_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]          checksum_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                       state;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         full;
    logic                         push;
    logic                         pop;

    // Full is judged on the occupancy before this cycle's pop, so a request
    // arriving together with a pop on a full FIFO is taken on the next cycle.
    assign full      = (level == FULL_LVL);
    assign push      = (state == IDLE) && req_in && !full;
    assign pop       = out_valid && out_ready;
    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack_out    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            byte_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        state   <= ACK;
                        ack_out <= 1'b1;
                    end
                end
                ACK: begin
                    // Hold ack until the master drops req; a req held high
                    // here never produces a second write.
                    if (!req_in) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
                end
            endcase

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                byte_count <= byte_count + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HSRX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)       checksum_out <= '0;
        else if (push) checksum_out <= checksum_out ^ data_in;
    end
`endif

endmodule
